// File: rtl/usart_packet_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : usart_packet_manager_if
// Description : Bundles the packet-manager buses:
//                 rx_*   packet stream from the USART receiver
//                 cmd_*  show-ahead command head towards the decoder
//                 resp_* response packets from the decoder
//                 tx_*   packet stream to the USART transmitter
//                 data_sent / err_count / rx_level  status outputs
//               slave  = manager side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface usart_packet_manager_if #(
   parameter int MSG_LENGTH    = 48,
   parameter int DATA_LENGTH   = 32,
   parameter int ADDRWIDTH     = 8,
   parameter int COMMAND_WIDTH = 5,
   parameter int RX_DEPTH      = 4
);
   logic [MSG_LENGTH-1:0]      rx_data;
   logic                       rx_valid;
   logic                       rx_parity_error;
   logic                       rx_ready;

   logic                       cmd_valid;
   logic                       cmd_ready;
   logic [COMMAND_WIDTH-1:0]   cmd_command;
   logic [ADDRWIDTH-1:0]       cmd_addr;
   logic [DATA_LENGTH-1:0]     cmd_data;

   logic [MSG_LENGTH-1:0]      resp_data;
   logic                       resp_valid;
   logic                       resp_ready;

   logic [MSG_LENGTH-1:0]      tx_data;
   logic                       tx_valid;
   logic                       tx_ready;

   logic                       data_sent;
   logic [7:0]                 err_count;
   logic [$clog2(RX_DEPTH):0]  rx_level;

   modport slave (
      input  rx_data, rx_valid, rx_parity_error,
      output rx_ready,
      output cmd_valid, cmd_command, cmd_addr, cmd_data,
      input  cmd_ready,
      input  resp_data, resp_valid,
      output resp_ready,
      output tx_data, tx_valid,
      input  tx_ready,
      output data_sent, err_count, rx_level
   );

   modport master (
      output rx_data, rx_valid, rx_parity_error,
      input  rx_ready,
      input  cmd_valid, cmd_command, cmd_addr, cmd_data,
      output cmd_ready,
      output resp_data, resp_valid,
      input  resp_ready,
      input  tx_data, tx_valid,
      output tx_ready,
      input  data_sent, err_count, rx_level
   );
endinterface
`default_nettype wire

// File: rtl/usart_packet_manager.sv
`default_nettype none
// ============================================================================
// Module      : usart_packet_manager
// Description : Buffers received USART packets in a show-ahead RX FIFO and
//               splits the head into command/address/data fields. Outgoing
//               traffic is arbitrated between decoder responses and NACKs
//               generated for parity errors and response timeouts.
// Ports       : clk   - clock
//               rsnt  - asynchronous active-low reset
//               bus   - usart_packet_manager_if.slave (rx, cmd, resp, tx,
//                       data_sent, err_count, rx_level)
// Revision    : 1.0 - initial release
// ============================================================================
module usart_packet_manager #(
   parameter int                       MSG_LENGTH     = 48,
   parameter int                       DATA_LENGTH    = 32,
   parameter int                       ADDRWIDTH      = 8,
   parameter int                       COMMAND_WIDTH  = 5,
   parameter int                       RX_DEPTH       = 4,
   parameter int                       TIMEOUT_CYCLES = 1024,
   parameter logic [COMMAND_WIDTH-1:0] NACK_CMD       = 5'h1F
) (
   input  logic                  clk,
   input  logic                  rsnt,
   usart_packet_manager_if.slave bus
);

   localparam int c_AW = $clog2(RX_DEPTH);
   localparam int c_LW = c_AW + 1;
   localparam int c_FW = COMMAND_WIDTH + ADDRWIDTH + DATA_LENGTH;
   localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_TW-1:0] c_TMAX =
      c_TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [c_LW-1:0] c_FULL = c_LW'(RX_DEPTH);

   typedef enum logic [0:0] {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_t;

   // NACK packet: NACK command, zero address, error code in the data field
   function automatic logic [MSG_LENGTH-1:0] f_nack(input logic [DATA_LENGTH-1:0] code);
      f_nack = '0;
      f_nack[c_FW-1:0] = {NACK_CMD, {ADDRWIDTH{1'b0}}, code};
   endfunction

   // -------------------------------------------------------------------------
   // RX FIFO
   // -------------------------------------------------------------------------
   logic [c_FW-1:0] r_mem [RX_DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_LW-1:0] r_level;

   logic            w_full;
   logic            w_empty;
   logic            w_rx_hs;
   logic            w_push;
   logic            w_pop;
   logic            w_parity_evt;
   logic [c_FW-1:0] w_head;

   assign w_full       = (r_level == c_FULL);
   assign w_empty      = (r_level == '0);
   assign w_rx_hs      = bus.rx_valid && !w_full;
   assign w_push       = w_rx_hs && !bus.rx_parity_error;
   assign w_parity_evt = w_rx_hs && bus.rx_parity_error;
   assign w_pop        = !w_empty && bus.cmd_ready;

   // The head is forced to zero while empty so stale storage never shows
   assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

   assign bus.rx_ready    = !w_full;
   assign bus.cmd_valid   = !w_empty;
   assign bus.cmd_data    = w_head[DATA_LENGTH-1:0];
   assign bus.cmd_addr    = w_head[DATA_LENGTH +: ADDRWIDTH];
   assign bus.cmd_command = w_head[DATA_LENGTH+ADDRWIDTH +: COMMAND_WIDTH];
   assign bus.rx_level    = r_level;

   generate
      if (MSG_LENGTH > c_FW) begin : g_unused_upper
         logic w_unused_upper;
         assign w_unused_upper = ^bus.rx_data[MSG_LENGTH-1:c_FW];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.rx_data[c_FW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rsnt) begin
      if (!rsnt) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_LW'(1);
            2'b01:   r_level <= r_level - c_LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Response timeout
   // -------------------------------------------------------------------------
   tx_state_t       r_state;
   tx_state_t       w_state_next;
   logic            w_resp_ready;
   logic            w_resp_hs;
   logic            r_awaiting;
   logic [c_TW-1:0] r_timer;
   logic            w_timeout_evt;

   assign w_resp_hs     = bus.resp_valid && w_resp_ready;
   // A response landing on the final cycle still counts as in time
   assign w_timeout_evt = (TIMEOUT_CYCLES != 0) && r_awaiting && !w_resp_hs &&
                          (r_timer == c_TMAX);

   always_ff @(posedge clk or negedge rsnt) begin
      if (!rsnt) begin
         r_awaiting <= 1'b0;
         r_timer    <= '0;
      end else if (w_pop) begin
         // A new pop restarts the wait even if a response completes now
         r_awaiting <= 1'b1;
         r_timer    <= '0;
      end else if (w_resp_hs || w_timeout_evt) begin
         r_awaiting <= 1'b0;
      end else if (r_awaiting) begin
         r_timer <= r_timer + c_TW'(1);
      end
   end

   // -------------------------------------------------------------------------
   // NACK flags and error counter
   // -------------------------------------------------------------------------
   logic       r_nack_parity;
   logic       r_nack_timeout;
   logic       w_clr_parity;
   logic       w_clr_timeout;
   logic [7:0] r_err_count;
   logic [8:0] w_err_sum;

   assign w_err_sum = {1'b0, r_err_count} + {8'd0, w_parity_evt} + {8'd0, w_timeout_evt};
   assign bus.err_count = r_err_count;

   always_ff @(posedge clk or negedge rsnt) begin
      if (!rsnt) begin
         r_nack_parity  <= 1'b0;
         r_nack_timeout <= 1'b0;
         r_err_count    <= '0;
      end else begin
         // Setting wins over clearing so an error in the load cycle is not lost
         if (w_parity_evt)       r_nack_parity <= 1'b1;
         else if (w_clr_parity)  r_nack_parity <= 1'b0;
         if (w_timeout_evt)      r_nack_timeout <= 1'b1;
         else if (w_clr_timeout) r_nack_timeout <= 1'b0;
         r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      end
   end

   // -------------------------------------------------------------------------
   // TX arbitration FSM
   // -------------------------------------------------------------------------
   logic [MSG_LENGTH-1:0] r_tx_data;
   logic [MSG_LENGTH-1:0] w_tx_next;
   logic                  r_data_sent;

   always_comb begin
      w_state_next  = r_state;
      w_tx_next     = r_tx_data;
      w_resp_ready  = 1'b0;
      w_clr_parity  = 1'b0;
      w_clr_timeout = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (r_nack_parity) begin
               w_tx_next    = f_nack(DATA_LENGTH'(1));
               w_clr_parity = 1'b1;
               w_state_next = TX_SEND;
            end else if (r_nack_timeout) begin
               w_tx_next     = f_nack(DATA_LENGTH'(2));
               w_clr_timeout = 1'b1;
               w_state_next  = TX_SEND;
            end else if (bus.resp_valid) begin
               w_tx_next    = bus.resp_data;
               w_resp_ready = 1'b1;
               w_state_next = TX_SEND;
            end
         end
         TX_SEND: begin
            if (bus.tx_ready) w_state_next = TX_IDLE;
         end
         default: w_state_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rsnt) begin
      if (!rsnt) begin
         r_state     <= TX_IDLE;
         r_tx_data   <= '0;
         r_data_sent <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_tx_data   <= w_tx_next;
         r_data_sent <= (r_state == TX_SEND) && bus.tx_ready;
      end
   end

   assign bus.tx_valid   = (r_state == TX_SEND);
   assign bus.tx_data    = r_tx_data;
   assign bus.resp_ready = w_resp_ready;
   assign bus.data_sent  = r_data_sent;

endmodule
`default_nettype wire
